// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, exception causes, FSM states.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISAL_LD = 2'b01;
    localparam logic [1:0] EXC_MISAL_ST = 2'b10;
    localparam logic [1:0] EXC_ILL_SIZE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    // Byte-enable pattern of an aligned access at offset 0: (1 << bytes) - 1.
    function automatic logic [7:0] size_be(input logic [1:0] size);
        logic [7:0] be;
        case (size)
            SZ_B:    be = 8'h01;
            SZ_H:    be = 8'h03;
            SZ_W:    be = 8'h0F;
            default: be = 8'hFF;
        endcase
        return be;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_align_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            SZ_B:    m = 3'd0;
            SZ_H:    m = 3'd1;
            SZ_W:    m = 3'd3;
            default: m = 3'd7;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_pipe_if.sv
// Execute, writeback and data-memory signals of the load/store unit.
interface lsu_pipe_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned BE_W = XLEN / 8;

    logic            lsu_valid_i;
    logic            lsu_ready_o;
    logic            lsu_we_i;
    logic [1:0]      lsu_size_i;
    logic            lsu_unsigned_i;
    logic [XLEN-1:0] lsu_addr_i;
    logic [XLEN-1:0] lsu_wdata_i;
    logic [4:0]      lsu_rd_i;

    logic            wb_valid_o;
    logic [4:0]      wb_rd_o;
    logic [XLEN-1:0] wb_data_o;
    logic            done_o;
    logic            exc_o;
    logic [1:0]      exc_cause_o;

    logic            mem_req_o;
    logic            mem_gnt_i;
    logic            mem_we_o;
    logic [BE_W-1:0] mem_be_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    modport slave (
        input  lsu_valid_i, lsu_we_i, lsu_size_i, lsu_unsigned_i, lsu_addr_i, lsu_wdata_i, lsu_rd_i,
        output lsu_ready_o,
        output wb_valid_o, wb_rd_o, wb_data_o, done_o, exc_o, exc_cause_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output lsu_valid_i, lsu_we_i, lsu_size_i, lsu_unsigned_i, lsu_addr_i, lsu_wdata_i, lsu_rd_i,
        input  lsu_ready_o,
        input  wb_valid_o, wb_rd_o, wb_data_o, done_o, exc_o, exc_cause_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/lsu_align.sv
// Lane alignment: byte enables and store-data shift, load-data extract and extend.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]                  size,
    input  logic                        uns,
    input  logic [$clog2(XLEN/8)-1:0]   off,
    input  logic [XLEN-1:0]             wdata,
    input  logic [XLEN-1:0]             rdata,
    output logic [XLEN/8-1:0]           be_c,
    output logic [XLEN-1:0]             wdata_c,
    output logic [XLEN-1:0]             rdata_c
);
    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);

    logic [XLEN-1:0]    rd_sh;
    logic [XLEN-1:0]    keep_mask;
    logic               msb;
    logic [OFF_W+2:0]   bit_sh;

    assign bit_sh  = {off, 3'b000};
    assign be_c    = BE_W'(size_be(size)) << off;
    assign wdata_c = wdata << bit_sh;
    assign rd_sh   = rdata >> bit_sh;

    // Pick the field width and its sign bit, then sign- or zero-fill above it.
    always_comb begin
        keep_mask = '1;
        msb       = 1'b0;
        case (size)
            SZ_B: begin
                keep_mask = XLEN'(8'hFF);
                msb       = rd_sh[7];
            end
            SZ_H: begin
                keep_mask = XLEN'(16'hFFFF);
                msb       = rd_sh[15];
            end
            SZ_W: begin
                keep_mask = XLEN'(32'hFFFF_FFFF);
                msb       = rd_sh[31];
            end
            default: begin
                keep_mask = '1;
                msb       = 1'b0;
            end
        endcase
        rdata_c = (msb && !uns) ? (rd_sh | ~keep_mask) : (rd_sh & keep_mask);
    end

endmodule

// File: rtl/lsu_pipe.sv
// Single-outstanding load/store unit between execute and the data-memory port.
module lsu_pipe
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic        clk,
    input  logic        rstn,
    lsu_pipe_if.slave   bus
);
    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);

    lsu_state_e         state_q, state_d;

    logic               accept_c, illegal_c, misal_c, exc_c;
    logic [OFF_W-1:0]   in_off_c;

    logic [1:0]         op_size_q, op_size_d;
    logic               op_uns_q, op_uns_d;
    logic [OFF_W-1:0]   op_off_q, op_off_d;
    logic [4:0]         op_rd_q, op_rd_d;

    logic               ready_q, ready_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic               wb_valid_q, wb_valid_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;
    logic               done_q, done_d;
    logic               exc_q, exc_d;
    logic [1:0]         cause_q, cause_d;

    logic [1:0]         al_size;
    logic               al_uns;
    logic [OFF_W-1:0]   al_off;
    logic [BE_W-1:0]    al_be;
    logic [XLEN-1:0]    al_wdata, al_rdata;

    assign in_off_c  = bus.lsu_addr_i[OFF_W-1:0];
    assign accept_c  = bus.lsu_valid_i && ready_q && (state_q == ST_IDLE);
    assign illegal_c = (XLEN < 64) && (bus.lsu_size_i == SZ_D);
    assign misal_c   = (in_off_c & OFF_W'(size_align_mask(bus.lsu_size_i))) != '0;
    assign exc_c     = illegal_c || misal_c;

    // The aligner sees the incoming op while idle, the latched op afterwards.
    assign al_size = (state_q == ST_IDLE) ? bus.lsu_size_i     : op_size_q;
    assign al_uns  = (state_q == ST_IDLE) ? bus.lsu_unsigned_i : op_uns_q;
    assign al_off  = (state_q == ST_IDLE) ? in_off_c           : op_off_q;

    lsu_align #(.XLEN(XLEN)) u_align (
        .size    (al_size),
        .uns     (al_uns),
        .off     (al_off),
        .wdata   (bus.lsu_wdata_i),
        .rdata   (bus.mem_rdata_i),
        .be_c    (al_be),
        .wdata_c (al_wdata),
        .rdata_c (al_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rstn) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: exceptions stay idle, otherwise request then wait for the response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c && !exc_c) state_d = ST_REQ;
            ST_REQ:  if (bus.mem_gnt_i)      state_d = ST_WAIT;
            ST_WAIT: if (bus.mem_rvalid_i)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values: buses and writeback data hold, pulses default low.
    always_comb begin
        op_size_d  = op_size_q;
        op_uns_d   = op_uns_q;
        op_off_d   = op_off_q;
        op_rd_d    = op_rd_q;
        ready_d    = ready_q;
        req_d      = req_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = 1'b0;
        done_d     = 1'b0;
        exc_d      = 1'b0;
        cause_d    = EXC_NONE;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (exc_c) begin
                        exc_d   = 1'b1;
                        cause_d = illegal_c       ? EXC_ILL_SIZE :
                                  bus.lsu_we_i    ? EXC_MISAL_ST : EXC_MISAL_LD;
                    end else begin
                        op_size_d = bus.lsu_size_i;
                        op_uns_d  = bus.lsu_unsigned_i;
                        op_off_d  = in_off_c;
                        op_rd_d   = bus.lsu_rd_i;
                        ready_d   = 1'b0;
                        req_d     = 1'b1;
                        we_d      = bus.lsu_we_i;
                        be_d      = al_be;
                        addr_d    = {bus.lsu_addr_i[XLEN-1:OFF_W], OFF_W'(0)};
                        wdata_d   = al_wdata;
                    end
                end
            end
            ST_REQ: begin
                if (bus.mem_gnt_i) req_d = 1'b0;
            end
            ST_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    if (!we_q) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = op_rd_q;
                        wb_data_d  = al_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and latched operation fields.
    always_ff @(posedge clk) begin
        if (rstn) begin
            op_size_q  <= SZ_B;
            op_uns_q   <= 1'b0;
            op_off_q   <= '0;
            op_rd_q    <= '0;
            ready_q    <= 1'b1;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            done_q     <= 1'b0;
            exc_q      <= 1'b0;
            cause_q    <= EXC_NONE;
        end else begin
            op_size_q  <= op_size_d;
            op_uns_q   <= op_uns_d;
            op_off_q   <= op_off_d;
            op_rd_q    <= op_rd_d;
            ready_q    <= ready_d;
            req_q      <= req_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            done_q     <= done_d;
            exc_q      <= exc_d;
            cause_q    <= cause_d;
        end
    end

    assign bus.lsu_ready_o = ready_q;
    assign bus.mem_req_o   = req_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_be_o    = be_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.wb_valid_o  = wb_valid_q;
    assign bus.wb_rd_o     = wb_rd_q;
    assign bus.wb_data_o   = wb_data_q;
    assign bus.done_o      = done_q;
    assign bus.exc_o       = exc_q;
    assign bus.exc_cause_o = cause_q;

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe at XLEN=32 and XLEN=64 with a per-cycle reference check.
module tb_lsu_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_pipe_if #(.XLEN(32)) if32 ();
    lsu_pipe_if #(.XLEN(64)) if64 ();

    lsu_pipe #(.XLEN(32)) u32 (.clk(clk), .rstn(rst), .bus(if32));
    lsu_pipe #(.XLEN(64)) u64 (.clk(clk), .rstn(rst), .bus(if64));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;
    int acc_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference expectations for the current cycle, per instance (0: XLEN=32, 1: XLEN=64).
    bit          e_ready[2], e_req[2], e_we[2], e_exc[2], e_done[2], e_wbv[2];
    logic [1:0]  e_cause[2];
    logic [7:0]  e_be[2];
    logic [63:0] e_addr[2], e_wd[2], e_wbd[2];
    logic [4:0]  e_rd[2];

    // Observations used by the literal pins.
    logic [7:0]  o_be[2];
    logic [63:0] o_addr[2], o_wd[2], o_wbd[2];
    logic [1:0]  o_cause[2];
    int          req_cnt[2], wb_cnt[2], done_cnt[2], wb_cyc[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", nm, act, exp);
        end
    endtask

    // Spec formulas evaluated with plain arithmetic.
    function automatic logic [7:0] m_be(input int sz, input int off);
        int v;
        v = ((1 << (1 << sz)) - 1) << off;
        return 8'(v);
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rdata, input int sz, input bit uns, input int off);
        int          nb;
        logic [63:0] v;
        logic [63:0] mask;
        nb = 1 << sz;
        v  = rdata >> (8 * off);
        if (nb == 8) return v;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = v & mask;
        if (!uns && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic int m_exc(input int xl, input int sz, input bit we, input logic [63:0] addr);
        if (xl == 32 && sz == 3) return 3;
        if ((addr % 64'(1 << sz)) != 64'd0) return we ? 2 : 1;
        return 0;
    endfunction

    task automatic cmp_inst(input int i);
        logic        rdy, req, we, exc, done, wbv;
        logic [1:0]  cause;
        logic [7:0]  be;
        logic [63:0] addr, wd, wbd;
        logic [4:0]  rd;
        string       p;
        if (i == 0) begin
            p = "x32"; rdy = if32.lsu_ready_o; req = if32.mem_req_o; we = if32.mem_we_o;
            be = 8'(if32.mem_be_o); addr = 64'(if32.mem_addr_o); wd = 64'(if32.mem_wdata_o);
            exc = if32.exc_o; cause = if32.exc_cause_o; done = if32.done_o;
            wbv = if32.wb_valid_o; wbd = 64'(if32.wb_data_o); rd = if32.wb_rd_o;
        end else begin
            p = "x64"; rdy = if64.lsu_ready_o; req = if64.mem_req_o; we = if64.mem_we_o;
            be = if64.mem_be_o; addr = if64.mem_addr_o; wd = if64.mem_wdata_o;
            exc = if64.exc_o; cause = if64.exc_cause_o; done = if64.done_o;
            wbv = if64.wb_valid_o; wbd = if64.wb_data_o; rd = if64.wb_rd_o;
        end
        chk({p, " lsu_ready"}, 64'(rdy), 64'(e_ready[i]));
        chk({p, " mem_req"},   64'(req), 64'(e_req[i]));
        chk({p, " exc"},       64'(exc), 64'(e_exc[i]));
        chk({p, " done"},      64'(done), 64'(e_done[i]));
        chk({p, " wb_valid"},  64'(wbv), 64'(e_wbv[i]));
        if (e_req[i]) begin
            chk({p, " mem_we"},    64'(we), 64'(e_we[i]));
            chk({p, " mem_be"},    64'(be), 64'(e_be[i]));
            chk({p, " mem_addr"},  addr, e_addr[i]);
            chk({p, " mem_wdata"}, wd, e_wd[i]);
        end
        if (e_exc[i]) chk({p, " exc_cause"}, 64'(cause), 64'(e_cause[i]));
        if (e_wbv[i]) begin
            chk({p, " wb_data"}, wbd, e_wbd[i]);
            chk({p, " wb_rd"},   64'(rd), 64'(e_rd[i]));
        end
        if (req) begin
            req_cnt[i]++;
            o_be[i] = be; o_addr[i] = addr; o_wd[i] = wd;
        end
        if (exc)  o_cause[i] = cause;
        if (done) done_cnt[i]++;
        if (wbv) begin
            wb_cnt[i]++;
            wb_cyc[i] = cyc;
            o_wbd[i]  = wbd;
        end
    endtask

    // Check mid-cycle, then move to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        if (chk_en) begin
            cmp_inst(0);
            cmp_inst(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input bit v, input bit we, input int sz, input bit uns,
                          input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
        if (i == 0) begin
            if32.lsu_valid_i = v; if32.lsu_we_i = we; if32.lsu_size_i = 2'(sz);
            if32.lsu_unsigned_i = uns; if32.lsu_addr_i = 32'(addr); if32.lsu_wdata_i = 32'(wd);
            if32.lsu_rd_i = rd;
        end else begin
            if64.lsu_valid_i = v; if64.lsu_we_i = we; if64.lsu_size_i = 2'(sz);
            if64.lsu_unsigned_i = uns; if64.lsu_addr_i = addr; if64.lsu_wdata_i = wd;
            if64.lsu_rd_i = rd;
        end
    endtask

    task automatic set_mem(input int i, input bit gnt, input bit rv, input logic [63:0] rdata);
        if (i == 0) begin
            if32.mem_gnt_i = gnt; if32.mem_rvalid_i = rv; if32.mem_rdata_i = 32'(rdata);
        end else begin
            if64.mem_gnt_i = gnt; if64.mem_rvalid_i = rv; if64.mem_rdata_i = rdata;
        end
    endtask

    // One operation end to end; expectations follow the documented cycle timing.
    task automatic run_op(input int i, input bit we, input int sz, input bit uns,
                          input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd,
                          input int gnt_dly, input int rv_dly, input logic [63:0] rdata,
                          input bit stray, input bit rst_wait);
        int          xl, off, ex;
        logic [63:0] xmask;
        xl    = (i == 0) ? 32 : 64;
        xmask = (i == 0) ? 64'h0000_0000_FFFF_FFFF : '1;
        off   = int'(addr % 64'(xl / 8));
        acc_cyc = cyc;
        set_in(i, 1'b1, we, sz, uns, addr, wd, rd);
        step();
        set_in(i, 1'b0, 1'b0, 0, 1'b0, '0, '0, '0);
        ex = m_exc(xl, sz, we, addr);
        if (ex != 0) begin
            e_exc[i] = 1'b1; e_cause[i] = 2'(ex);
            step();
            e_exc[i] = 1'b0;
            return;
        end
        e_req[i]   = 1'b1;
        e_ready[i] = 1'b0;
        e_we[i]    = we;
        e_be[i]    = m_be(sz, off) & ((i == 0) ? 8'h0F : 8'hFF);
        e_addr[i]  = (addr - 64'(off)) & xmask;
        e_wd[i]    = (wd << (8 * off)) & xmask;
        for (int k = 0; k < gnt_dly; k++) begin
            if (stray && k == 0) set_mem(i, 1'b0, 1'b1, rdata);
            else                 set_mem(i, 1'b0, 1'b0, '0);
            step();
        end
        set_mem(i, 1'b1, 1'b0, '0);
        step();
        set_mem(i, 1'b0, 1'b0, '0);
        e_req[i] = 1'b0;
        for (int k = 0; k < rv_dly; k++) step();
        if (rst_wait) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            e_ready[i] = 1'b1;
            set_mem(i, 1'b0, 1'b1, rdata);
            step();
            set_mem(i, 1'b0, 1'b0, '0);
            step();
            return;
        end
        set_mem(i, 1'b0, 1'b1, rdata);
        step();
        set_mem(i, 1'b0, 1'b0, '0);
        e_done[i]  = 1'b1;
        e_ready[i] = 1'b1;
        if (!we) begin
            e_wbv[i] = 1'b1;
            e_wbd[i] = m_load(rdata & xmask, sz, uns, off) & xmask;
            e_rd[i]  = rd;
        end
        step();
        e_done[i] = 1'b0;
        e_wbv[i]  = 1'b0;
    endtask

    initial begin
        int r0, w0, d0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_in(i, 1'b0, 1'b0, 0, 1'b0, '0, '0, '0);
            set_mem(i, 1'b0, 1'b0, '0);
            e_ready[i] = 1'b1; e_req[i] = 1'b0; e_we[i] = 1'b0; e_exc[i] = 1'b0;
            e_done[i] = 1'b0; e_wbv[i] = 1'b0; e_cause[i] = '0; e_be[i] = '0;
            e_addr[i] = '0; e_wd[i] = '0; e_wbd[i] = '0; e_rd[i] = '0;
            o_be[i] = '0; o_addr[i] = '0; o_wd[i] = '0; o_wbd[i] = '0; o_cause[i] = '0;
            req_cnt[i] = 0; wb_cnt[i] = 0; done_cnt[i] = 0; wb_cyc[i] = 0;
        end
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("x32 reset mem_addr",  64'(if32.mem_addr_o), 64'd0);
        chk("x32 reset mem_be",    64'(if32.mem_be_o), 64'd0);
        chk("x32 reset mem_wdata", 64'(if32.mem_wdata_o), 64'd0);
        chk("x32 reset wb_data",   64'(if32.wb_data_o), 64'd0);
        chk("x64 reset mem_addr",  if64.mem_addr_o, 64'd0);
        chk("x64 reset wb_data",   if64.wb_data_o, 64'd0);
        step();
        rst = 1'b0;
        step();

        // LB at 0x103, immediate gnt/rvalid
        run_op(0, 1'b0, 0, 1'b0, 64'h103, '0, 5'd3, 0, 0, 64'h80FF1234, 1'b0, 1'b0);
        chk("lb be lit",      64'(o_be[0]), 64'h8);
        chk("lb wb_data lit", o_wbd[0], 64'hFFFF_FF80);
        chk("lb latency lit", 64'(wb_cyc[0] - acc_cyc), 64'd3);

        // LHU at 0x102
        run_op(0, 1'b0, 1, 1'b1, 64'h102, '0, 5'd4, 0, 1, 64'hBEEF0000, 1'b0, 1'b0);
        chk("lhu be lit",      64'(o_be[0]), 64'hC);
        chk("lhu addr lit",    o_addr[0], 64'h100);
        chk("lhu wb_data lit", o_wbd[0], 64'h0000_BEEF);

        // SB at 0x101
        w0 = wb_cnt[0]; d0 = done_cnt[0];
        run_op(0, 1'b1, 0, 1'b0, 64'h101, 64'hA5, 5'd0, 0, 0, '0, 1'b0, 1'b0);
        chk("sb be lit",    64'(o_be[0]), 64'h2);
        chk("sb wdata lit", o_wd[0], 64'h0000_A500);
        chk("sb done cnt",  64'(done_cnt[0] - d0), 64'd1);
        chk("sb no wb",     64'(wb_cnt[0] - w0), 64'd0);

        // Exceptions: misaligned LW, illegal size, misaligned SW
        r0 = req_cnt[0];
        run_op(0, 1'b0, 2, 1'b0, 64'h102, '0, 5'd1, 0, 0, '0, 1'b0, 1'b0);
        chk("lw misal cause lit", 64'(o_cause[0]), 64'd1);
        run_op(0, 1'b0, 3, 1'b0, 64'h100, '0, 5'd1, 0, 0, '0, 1'b0, 1'b0);
        chk("size11 cause lit", 64'(o_cause[0]), 64'd3);
        run_op(0, 1'b1, 2, 1'b0, 64'h101, 64'h1, 5'd1, 0, 0, '0, 1'b0, 1'b0);
        chk("sw misal cause lit", 64'(o_cause[0]), 64'd2);
        chk("exc no mem_req", 64'(req_cnt[0] - r0), 64'd0);

        // Delayed gnt with a stray rvalid during REQ
        r0 = req_cnt[0];
        run_op(0, 1'b0, 2, 1'b0, 64'h104, '0, 5'd9, 3, 2, 64'h1234_5678, 1'b1, 1'b0);
        chk("gnt delay req cycles", 64'(req_cnt[0] - r0), 64'd4);
        chk("gnt delay wb_data",    o_wbd[0], 64'h1234_5678);

        // More patterns: SH lane shift, LH signed, LWU at XLEN=32
        run_op(0, 1'b1, 1, 1'b0, 64'h106, 64'h1234BEEF, 5'd0, 1, 0, '0, 1'b0, 1'b0);
        chk("sh wdata lit", o_wd[0], 64'hBEEF_0000);
        run_op(0, 1'b0, 1, 1'b0, 64'h200, '0, 5'd7, 0, 0, 64'h0000_8001, 1'b0, 1'b0);
        chk("lh sign lit", o_wbd[0], 64'hFFFF_8001);
        run_op(0, 1'b0, 2, 1'b1, 64'h204, '0, 5'd8, 0, 0, 64'h8000_0000, 1'b0, 1'b0);
        chk("lwu x32 lit", o_wbd[0], 64'h8000_0000);

        // XLEN=64: LD, LW signed/unsigned, misaligned LD, reset in WAIT
        run_op(1, 1'b0, 3, 1'b0, 64'h0000_1000_0000_0008, '0, 5'd10, 0, 0, 64'h8000_0000_0000_0001, 1'b0, 1'b0);
        chk("ld be lit",      64'(o_be[1]), 64'hFF);
        chk("ld wb_data lit", o_wbd[1], 64'h8000_0000_0000_0001);
        run_op(1, 1'b0, 2, 1'b0, 64'h0000_1000_0000_000C, '0, 5'd11, 0, 0, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        chk("lw x64 sign lit", o_wbd[1], 64'hFFFF_FFFF_8000_0000);
        run_op(1, 1'b0, 2, 1'b1, 64'h0000_1000_0000_000C, '0, 5'd12, 0, 0, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        chk("lwu x64 lit", o_wbd[1], 64'h0000_0000_8000_0000);
        run_op(1, 1'b1, 1, 1'b0, 64'h0000_1000_0000_0006, 64'hCAFE, 5'd0, 0, 0, '0, 1'b0, 1'b0);
        chk("sh x64 be lit",    64'(o_be[1]), 64'hC0);
        chk("sh x64 wdata lit", o_wd[1], 64'hCAFE_0000_0000_0000);
        run_op(1, 1'b0, 3, 1'b0, 64'h0000_1000_0000_0004, '0, 5'd1, 0, 0, '0, 1'b0, 1'b0);
        chk("ld misal cause lit", 64'(o_cause[1]), 64'd1);
        w0 = wb_cnt[1]; d0 = done_cnt[1];
        run_op(1, 1'b0, 3, 1'b0, 64'h0000_1000_0000_0010, '0, 5'd13, 0, 1, 64'h1234, 1'b0, 1'b1);
        chk("rst wait no wb",   64'(wb_cnt[1] - w0), 64'd0);
        chk("rst wait no done", 64'(done_cnt[1] - d0), 64'd0);
        run_op(1, 1'b0, 0, 1'b1, 64'h0000_1000_0000_0013, '0, 5'd14, 0, 0, 64'h0000_0000_9900_0000, 1'b0, 1'b0);
        chk("lbu x64 after rst lit", o_wbd[1], 64'h99);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_pipe.md
# lsu_pipe

Parametrised, handshaked load/store unit sitting between the execute stage and the data-memory port. Accepts one memory operation at a time from execute. Generates aligned byte enables and lane-shifted write data. Drives a request/grant/response memory interface, then returns sign- or zero-extended load data to register writeback. Adds XLEN generality (32/64) and multi-cycle memory latency, with misalignment and illegal-size exceptions.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64
- BE_W, XLEN/8, byte-enable width (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  synchronous, active-high reset (1 = reset), sampled on rising edge of clk
- lsu_valid_i  in  1  execute presents an operation
- lsu_ready_o  out  1  unit can accept; high only in IDLE
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_size_i  in  2  00 byte, 01 half, 10 word, 11 double
- lsu_unsigned_i  in  1  zero-extend load (LBU/LHU/LWU)
- lsu_addr_i  in  XLEN  effective address (ALU result)
- lsu_wdata_i  in  XLEN  store data, right-aligned
- lsu_rd_i  in  5  destination register of load
- wb_valid_o  out  1  one-cycle pulse, load data valid
- wb_rd_o  out  5  destination register
- wb_data_o  out  XLEN  extended load data
- done_o  out  1  one-cycle pulse, operation retired (load or store)
- exc_o  out  1  one-cycle exception pulse
- exc_cause_o  out  2  01 misaligned load, 10 misaligned store, 11 illegal size
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory accepted request
- mem_we_o  out  1  write
- mem_be_o  out  BE_W  byte enables
- mem_addr_o  out  XLEN  address, low log2(BE_W) bits forced to 0
- mem_wdata_o  out  XLEN  lane-shifted store data
- mem_rvalid_i  in  1  response (load data or store ack)
- mem_rdata_i  in  XLEN  load data, full aligned word

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - lsu_valid_i & lsu_ready_o latches the operation.
  - Size 11 with XLEN=32 raises cause 11.
  - Address not naturally aligned to the size raises cause 01 (load) or 10 (store).
  - Exceptions pulse exc_o next cycle, issue no memory request, and stay in IDLE.
  - Otherwise go to REQ.
- REQ:
  - mem_req_o=1; mem_addr_o, mem_be_o, mem_we_o and mem_wdata_o are held stable until mem_gnt_i.
  - On gnt go to WAIT.
- WAIT:
  - On mem_rvalid_i, a load captures mem_rdata_i, shifts it right by offset*8, and sign- or zero-extends from the size. It then pulses wb_valid_o and done_o.
  - A store pulses done_o only.
  - Either case returns to IDLE.
- Byte enables are ((1<<(1<<size))-1) << offset, where offset = addr[log2(BE_W)-1:0].
- mem_wdata_o is lsu_wdata_i shifted left by offset*8.
- Size 10 with unsigned at XLEN=32 is the same as signed.
- mem_rvalid_i in IDLE or REQ is ignored.
- Only one outstanding transaction is allowed.

## Timing
- Reset values:
  - FSM in IDLE.
  - lsu_ready_o=1; every other output 0, including buses.
- Accept at cycle N → mem_req_o high at N+1.
- gnt at N+1 → WAIT at N+2; rvalid at N+2 → wb_valid_o/done_o at N+3. Minimum load-to-writeback latency is 3 cycles.
- gnt and rvalid are never in the same cycle; the memory guarantees rvalid ≥1 cycle after gnt.
- Exception path: accept at N → exc_o at N+1; lsu_ready_o stays high.
- wb_data_o and wb_rd_o hold their value until the next load completes. They are meaningful only while wb_valid_o=1.
- Reset asserted in REQ or WAIT:
  - next cycle is IDLE with mem_req_o=0;
  - no wb_valid_o or done_o is produced;
  - a late rvalid is ignored.

## Structure
- Shared package lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - exc cause constants;
  - FSM state enum.
- One natural sub-module, lsu_align: combinational BE/wdata shift and rdata extract/extend, parametrised by XLEN. It is reused by the future misaligned-split LSU.

## Test plan
- XLEN=32, LB at 0x103, rdata 0x80FF1234 → mem_be_o 1000, wb_data_o 0xFFFFFF80, wb_valid_o at N+3 with gnt/rvalid immediate.
- LHU at 0x102, rdata 0xBEEF0000 → mem_be_o 1100, mem_addr_o 0x100, wb_data_o 0x0000BEEF.
- SB at 0x101, wdata 0x000000A5 → mem_be_o 0010, mem_wdata_o 0x0000A500, done_o pulse, no wb_valid_o.
- LW at 0x102 → exc_o with cause 01 at N+1, mem_req_o never asserted; size 11 at XLEN=32 → cause 11.
- gnt delayed 3 cycles → mem_req_o and the address/BE/wdata buses stay stable for 4 cycles. A stray rvalid during REQ is ignored.
- XLEN=64, LD at 0x...8, rdata 0x8000000000000001 → be 0xFF, wb_data_o unchanged. Reset asserted in WAIT → IDLE next cycle, a subsequent rvalid produces no wb_valid_o.
